// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmit types and constants; UART_TX_PARITY_EN adds the PARITY state
package uart_pkg;
  localparam int UART_DATA_BITS = 8;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_tx_state_t;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit byte FIFO owning pointers, occupancy and registered full/empty flags
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      nRst,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] wdata,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] rdata,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;
  logic [AW:0]   count_n;
  assign rdata = mem[rd_ptr];
  // qualify requests against the registered flags and form the next occupancy
  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    count_n = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end
  // storage array needs no reset; only accepted pushes write it
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= wdata;
  // pointers wrap naturally at the power-of-two depth; flags are registered from the next count
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count_n;
      full  <= count_n == (AW+1)'(DEPTH);
      empty <= count_n == '0;
    end
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: FIFO-buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for an even-parity bit
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic [DIV_W-1:0]            baud_div,
  input  logic                        ovf_clr,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        busy,
  output logic                        ovf,
  output logic                        tx
);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);
  uart_tx_state_t            state;
  logic [DIV_W-1:0]          div_q;
  logic [DIV_W-1:0]          baud_cnt;
  logic [BW-1:0]             bit_cnt;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] rd_data;
  logic                      bit_end;
  logic                      start;
  logic                      drop;
`ifdef UART_TX_PARITY_EN
  logic                      par;
`endif
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .nRst  (nRst),
    .push  (wr_en),
    .wdata (wr_data),
    .pop   (start),
    .rdata (rd_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );
  // a new frame starts from IDLE or straight out of a finished stop bit, popping the FIFO head
  always_comb begin
    bit_end = baud_cnt == div_q;
    start   = !empty && (state == IDLE || (state == STOP && bit_end));
    drop    = wr_en && full;
  end
  // frame sequencer: baud_div is latched per frame, tx and busy are registered alongside the state
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      div_q    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
`ifdef UART_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else if (start) begin
      state    <= START;
      tx       <= 1'b0;
      busy     <= 1'b1;
      div_q    <= baud_div;
      baud_cnt <= '0;
      shift    <= rd_data;
`ifdef UART_TX_PARITY_EN
      par      <= ^rd_data;
`endif
    end else begin
      if (state != IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
        START: if (bit_end) begin
          state   <= DATA;
          tx      <= shift[0];
          bit_cnt <= '0;
        end
        DATA: if (bit_end) begin
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state <= PARITY;
            tx    <= par;
`else
            state <= STOP;
            tx    <= 1'b1;
`endif
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shift   <= shift >> 1;
            tx      <= shift[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state <= STOP;
          tx    <= 1'b1;
        end
`endif
        STOP: if (bit_end) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  // sticky overflow: a drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) ovf <= 1'b0;
    else ovf <= drop ? 1'b1 : ovf_clr ? 1'b0 : ovf;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: waveform-queue model of uart_tx_ctrl plus directed scenarios with literal expectations
module tb_uart_tx_ctrl;
  localparam int DEPTH = 8;
  localparam int DIV_W = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  logic clk = 0;
  logic nRst = 0;
  logic wr_en = 0;
  logic ovf_clr = 0;
  logic [7:0] wr_data = 0;
  logic [DIV_W-1:0] baud_div = 0;
  logic full, empty, busy, ovf, tx;
  logic [3:0] count;
  int checks = 0;
  int errors = 0;

  uart_tx_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .nRst(nRst), .wr_en(wr_en), .wr_data(wr_data), .baud_div(baud_div),
    .ovf_clr(ovf_clr), .full(full), .empty(empty), .count(count), .busy(busy),
    .ovf(ovf), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // line level of bit k of a frame carrying byte b
  function automatic bit frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // model: byte queue plus a queue of future line levels, one entry per clock cycle
  logic [7:0] mq[$];
  bit mwave[$];
  bit m_tx = 1, m_busy = 0, m_ovf = 0;
  bit m_full_pre, m_empty_pre;
  logic [7:0] m_b;
  always @(posedge clk or negedge nRst)
    if (!nRst) begin
      mq.delete();
      mwave.delete();
      m_tx = 1;
      m_busy = 0;
      m_ovf = 0;
    end else begin
      m_full_pre = mq.size() == DEPTH;
      m_empty_pre = mq.size() == 0;
      if (mwave.size() == 0 && !m_empty_pre) begin
        m_b = mq.pop_front();
        for (int k = 0; k < FB; k++)
          for (int r = 0; r <= int'(baud_div); r++) mwave.push_back(frame_bit(m_b, k));
      end
      if (mwave.size() != 0) begin
        m_tx = mwave.pop_front();
        m_busy = 1;
      end else begin
        m_tx = 1;
        m_busy = 0;
      end
      if (wr_en && !m_full_pre) mq.push_back(wr_data);
      if (wr_en && m_full_pre) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end

  always @(negedge clk)
    if (nRst) begin
      chk("m_tx", tx, m_tx);
      chk("m_busy", busy, m_busy);
      chk("m_ovf", ovf, m_ovf);
      chk("m_full", full, mq.size() == DEPTH);
      chk("m_empty", empty, mq.size() == 0);
      chk("m_count", count, mq.size());
    end

  task automatic wait_low(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (tx == 1'b0) begin
        ok = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic push(input logic [7:0] b);
    wr_en = 1;
    wr_data = b;
    @(negedge clk);
  endtask

  initial begin
    bit ok;
    bit s[$];
    bit bz[$];
    logic [7:0] d;
    logic [FB-1:0] s1_exp;
    int lows;
`ifdef UART_TX_PARITY_EN
    s1_exp = 11'b10010101010;
`else
    s1_exp = 10'b1010101010;
`endif
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    nRst = 1;

    // single byte 0x55, 4 cycles per bit
    baud_div = 3;
    @(negedge clk);
    push(8'h55);
    wr_en = 0;
    chk("s1_lat_n1", tx, 1);
    @(negedge clk);
    for (int i = 0; i < 4 * FB; i++) begin
      chk("s1_bit", tx, s1_exp[i/4]);
      chk("s1_busy", busy, 1);
      @(negedge clk);
    end
    chk("s1_busy_end", busy, 0);

    // back-to-back 0xA3, 0x0F at one cycle per bit
    repeat (3) @(negedge clk);
    baud_div = 0;
    push(8'hA3);
    push(8'h0F);
    wr_en = 0;
    wait_low(10, ok);
    chk("s2_start_found", ok, 1);
    s.delete();
    bz.delete();
    for (int i = 0; i < 2 * FB; i++) begin
      s.push_back(tx);
      bz.push_back(busy);
      @(negedge clk);
    end
    for (int j = 0; j < 8; j++) d[j] = s[1+j];
    chk("s2_byte0", d, 8'hA3);
    for (int j = 0; j < 8; j++) d[j] = s[FB+1+j];
    chk("s2_byte1", d, 8'h0F);
    chk("s2_start0", s[0], 0);
    chk("s2_stop0", s[FB-1], 1);
    chk("s2_start1", s[FB], 0);
    chk("s2_stop1", s[2*FB-1], 1);
    lows = 0;
    foreach (bz[i]) lows += bz[i];
    chk("s2_busy_cycles", lows, 2 * FB);
    chk("s2_idle_after", busy, 0);

    // overflow: 10 consecutive pushes into a slow line
    repeat (3) @(negedge clk);
    baud_div = 100;
    for (int k = 0; k < 10; k++) begin
      if (k == 9) begin
        chk("s3_full_at8", full, 1);
        chk("s3_count_at8", count, 8);
        chk("s3_ovf_before", ovf, 0);
      end
      push(8'(k + 1));
    end
    wr_en = 0;
    chk("s3_ovf_set", ovf, 1);
    chk("s3_count", count, 8);
    chk("s3_full", full, 1);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    chk("s3_ovf_clr", ovf, 0);
    wr_en = 1;
    wr_data = 8'hEE;
    ovf_clr = 1;
    @(negedge clk);
    wr_en = 0;
    ovf_clr = 0;
    chk("s3_drop_beats_clr", ovf, 1);
    ovf_clr = 1;
    @(negedge clk);
    ovf_clr = 0;
    chk("s3_ovf_clr2", ovf, 0);

    // reset mid-frame during bit 4 of 0xFF, with a second byte queued
    nRst = 0;
    @(negedge clk);
    nRst = 1;
    baud_div = 3;
    @(negedge clk);
    push(8'hFF);
    push(8'h12);
    wr_en = 0;
    wait_low(10, ok);
    chk("s4_start_found", ok, 1);
    repeat (21) @(negedge clk);
    chk("s4_bit4", tx, 1);
    chk("s4_busy_mid", busy, 1);
    chk("s4_count_mid", count, 1);
    #2 nRst = 0;
    #1;
    chk("s4_rst_tx", tx, 1);
    chk("s4_rst_empty", empty, 1);
    chk("s4_rst_busy", busy, 0);
    chk("s4_rst_count", count, 0);
    @(negedge clk);
    nRst = 1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx == 1'b0 || busy) lows++;
      @(negedge clk);
    end
    chk("s4_no_frame", lows, 0);

    // divisor change mid-frame
    baud_div = 3;
    push(8'h0F);
    push(8'hF0);
    wr_en = 0;
    wait_low(10, ok);
    chk("s5_start_found", ok, 1);
    for (int i = 0; i < 12 * FB; i++) begin
      if (i == 10) baud_div = 7;
      if (i < 4 * FB) chk("s5_frame0", tx, frame_bit(8'h0F, i / 4));
      else chk("s5_frame1", tx, frame_bit(8'hF0, (i - 4 * FB) / 8));
      @(negedge clk);
    end
    chk("s5_idle_after", busy, 0);

    // 0x07 frame length and parity/stop placement
    baud_div = 0;
    push(8'h07);
    wr_en = 0;
    wait_low(10, ok);
    chk("s6_start_found", ok, 1);
    s.delete();
    bz.delete();
    for (int i = 0; i < FB + 1; i++) begin
      s.push_back(tx);
      bz.push_back(busy);
      @(negedge clk);
    end
    chk("s6_d0", s[1], 1);
    chk("s6_d2", s[3], 1);
    chk("s6_d3", s[4], 0);
    chk("s6_bit9", s[9], 1);
    chk("s6_last_busy", bz[FB-1], 1);
    chk("s6_after_busy", bz[FB], 0);
`ifdef UART_TX_PARITY_EN
    chk("s6_stop", s[10], 1);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
